// File: rtl/display_scan_if.sv
// Bundle between the number-generation logic (master) and the display scanner (slave):
// load data and handshake, display controls, and the registered display pin outputs.
interface display_scan_if #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned BRIGHT_BITS = 4
);
  logic [4*DIGITS-1:0]    digits_i;
  logic [DIGITS-1:0]      dp_i;
  logic                   load_valid;
  logic                   load_ready;
  logic                   blank_lz;
  logic [BRIGHT_BITS-1:0] brightness;
  logic [7:0]             seg_n;
  logic [DIGITS-1:0]      en_n;
  logic                   frame;

  modport master (
    output digits_i, dp_i, load_valid, blank_lz, brightness,
    input  load_ready, seg_n, en_n, frame
  );

  modport slave (
    input  digits_i, dp_i, load_valid, blank_lz, brightness,
    output load_ready, seg_n, en_n, frame
  );
endinterface

// File: rtl/display_scan.sv
// Multiplexed 7-segment scanner: double-buffered load, leading-zero blanking, PWM brightness.
// Define DISPLAY_SCAN_HEX_EN to decode codes 10-15 as A..F; otherwise they show blank.
module display_scan #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SCAN_BITS   = 13,
  parameter int unsigned BRIGHT_BITS = 4
) (
  input logic           clk,
  input logic           rst,
  display_scan_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DIGITS);

  logic [SCAN_BITS-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;

  logic [4*DIGITS-1:0]  act_dig_q, act_dig_d;
  logic [DIGITS-1:0]    act_dp_q, act_dp_d;
  logic [4*DIGITS-1:0]  pend_dig_q, pend_dig_d;
  logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
  logic                 pend_full_q, pend_full_d;

  logic [7:0]           seg_n_q, seg_n_d;
  logic [DIGITS-1:0]    en_n_q, en_n_d;
  logic                 frame_q, frame_d;

  logic                 dwell_end;
  logic                 last_digit;
  logic                 boundary;
  logic                 load_fire;
  logic                 bright_on;

  logic [DIGITS-1:0]    nib_zero;
  logic [DIGITS-1:0]    lz_run;
  logic [DIGITS-1:0]    lz_blank;
  logic [3:0]           cur_nib;
  logic                 cur_dp;
  logic                 cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] r;
    r = 7'h7F;
    case (nib)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
`ifdef DISPLAY_SCAN_HEX_EN
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
`endif
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  assign dwell_end  = &cnt_q;
  assign last_digit = (idx_q == IdxW'(DIGITS - 1));
  assign boundary   = dwell_end & last_digit;
  assign load_fire  = bus.load_valid & ~pend_full_q;

  // Scan counters
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (dwell_end) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end
  end

  // Promotion and acceptance are mutually exclusive: one needs pending full, the other empty.
  always_comb begin
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (boundary && pend_full_q) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (load_fire) begin
      pend_dig_d  = bus.digits_i;
      pend_dp_d   = bus.dp_i;
      pend_full_d = 1'b1;
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    nib_zero = '0;
    lz_run   = '0;
    lz_blank = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib_zero[i] = (act_dig_q[4*i +: 4] == 4'h0);
    end
    lz_run[DIGITS-1] = nib_zero[DIGITS-1];
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      lz_run[i] = lz_run[i+1] & nib_zero[i];
    end
    for (int i = 1; i < int'(DIGITS); i++) begin
      lz_blank[i] = lz_run[i];
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = act_dig_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = lz_blank[i];
      end
    end
  end

  assign bright_on = (cnt_q[SCAN_BITS-1 -: BRIGHT_BITS] < bus.brightness);

  always_comb begin
    seg_n_d = {~cur_dp, (bus.blank_lz && cur_blank) ? 7'h7F : seg_decode(cur_nib)};
    en_n_d  = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      en_n_d[i] = ~(bright_on && (idx_q == IdxW'(i)));
    end
    frame_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      pend_dig_q  <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      pend_dig_q  <= pend_dig_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
    end
  end

  // Pin registers share one edge so segments, enables and frame never skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n_q <= 8'hFF;
      en_n_q  <= '1;
      frame_q <= 1'b0;
    end else begin
      seg_n_q <= seg_n_d;
      en_n_q  <= en_n_d;
      frame_q <= frame_d;
    end
  end

  assign bus.load_ready = ~pend_full_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.en_n       = en_n_q;
  assign bus.frame      = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: per-cycle expected pin values from a reference model are queued
// by each scenario and compared by a negedge monitor as the scanner produces them.
module tb_display_scan;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned SCAN_BITS   = 3;
  localparam int unsigned BRIGHT_BITS = 2;
  localparam int          DWELL       = 1 << SCAN_BITS;
  localparam int          FRAME_LEN   = DIGITS * DWELL;

  logic clk;
  logic rst;

  display_scan_if #(.DIGITS(DIGITS), .BRIGHT_BITS(BRIGHT_BITS)) bus ();

  display_scan #(
    .DIGITS     (DIGITS),
    .SCAN_BITS  (SCAN_BITS),
    .BRIGHT_BITS(BRIGHT_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        seg;
    logic [DIGITS-1:0] en;
    logic              frame;
    int                pos;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [6:0] ref_decode(input logic [3:0] n);
    logic [6:0] r;
    r = 7'h7F;
    case (n)
      4'd0: r = 7'h40;
      4'd1: r = 7'h79;
      4'd2: r = 7'h24;
      4'd3: r = 7'h30;
      4'd4: r = 7'h19;
      4'd5: r = 7'h12;
      4'd6: r = 7'h02;
      4'd7: r = 7'h78;
      4'd8: r = 7'h00;
      4'd9: r = 7'h10;
`ifdef DISPLAY_SCAN_HEX_EN
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
`endif
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] ref_seg(input logic [4*DIGITS-1:0] val,
                                         input logic [DIGITS-1:0] dp, input logic blank,
                                         input int d);
    logic [4*DIGITS-1:0] upper;
    logic                blanked;
    upper   = val >> (4 * d);
    blanked = blank && (d != 0) && (upper == '0);
    return {~dp[d], blanked ? 7'h7F : ref_decode(upper[3:0])};
  endfunction

  // Queue expected pins for frame positions j0..j1 (position 0 = frame pulse cycle).
  function automatic void push_frame(input logic [4*DIGITS-1:0] val,
                                     input logic [DIGITS-1:0] dp, input logic blank,
                                     input int bright, input int j0, input int j1);
    exp_t              e;
    logic [DIGITS-1:0] one;
    int                d;
    int                p;
    logic              on;
    one = 1;
    for (int j = j0; j <= j1; j++) begin
      d       = (j / DWELL) % DIGITS;
      p       = j % DWELL;
      on      = (p >> (SCAN_BITS - BRIGHT_BITS)) < bright;
      e.seg   = ref_seg(val, dp, blank, d);
      e.en    = on ? ~(one << d) : '1;
      e.frame = ((j % FRAME_LEN) == 0);
      e.pos   = j;
      sb_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checks += 3;
      if (bus.seg_n !== mon_e.seg) begin
        errors++;
        $display("FAIL seg_n pos=%0d got=%h exp=%h", mon_e.pos, bus.seg_n, mon_e.seg);
      end
      if (bus.en_n !== mon_e.en) begin
        errors++;
        $display("FAIL en_n pos=%0d got=%h exp=%h", mon_e.pos, bus.en_n, mon_e.en);
      end
      if (bus.frame !== mon_e.frame) begin
        errors++;
        $display("FAIL frame pos=%0d got=%b exp=%b", mon_e.pos, bus.frame, mon_e.frame);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    tick();
    while (bus.frame !== 1'b1 && n < 4 * FRAME_LEN) begin
      tick();
      n++;
    end
    checks++;
    if (bus.frame !== 1'b1) begin
      errors++;
      $display("FAIL frame_timeout got=%b exp=1", bus.frame);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.load_ready !== 1'b1 && n < 4 * FRAME_LEN) begin
      tick();
      n++;
    end
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got=%b exp=1", bus.load_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 8 * FRAME_LEN) begin
      tick();
      n++;
    end
    sb_q.delete();
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] val, input logic [DIGITS-1:0] dp);
    wait_ready();
    bus.digits_i   = val;
    bus.dp_i       = dp;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop val=%h got=%b exp=0", val, bus.load_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 4;
    if (bus.seg_n !== 8'hFF) begin
      errors++; $display("FAIL rst_seg got=%h exp=ff", bus.seg_n);
    end
    if (bus.en_n !== '1) begin
      errors++; $display("FAIL rst_en got=%h exp=f", bus.en_n);
    end
    if (bus.load_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got=%b exp=1", bus.load_ready);
    end
    if (bus.frame !== 1'b0) begin
      errors++; $display("FAIL rst_frame got=%b exp=0", bus.frame);
    end
    rst = 1'b0;
    tick();
    checks += 3;
    if (bus.frame !== 1'b1) begin
      errors++; $display("FAIL first_frame got=%b exp=1", bus.frame);
    end
    if (bus.en_n !== 4'hE) begin
      errors++; $display("FAIL first_en got=%h exp=e", bus.en_n);
    end
    if (bus.seg_n !== 8'hC0) begin
      errors++; $display("FAIL first_seg got=%h exp=c0", bus.seg_n);
    end
    tick();
    checks++;
    if (bus.frame !== 1'b0) begin
      errors++; $display("FAIL frame_single got=%b exp=0", bus.frame);
    end
    // Leave a load pending, then reset mid-frame: outputs blank at once, pending is dropped.
    do_load(16'h1111, 4'hF);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.seg_n !== 8'hFF) begin
      errors++; $display("FAIL mid_rst_seg got=%h exp=ff", bus.seg_n);
    end
    if (bus.en_n !== '1) begin
      errors++; $display("FAIL mid_rst_en got=%h exp=f", bus.en_n);
    end
    if (bus.load_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_ready got=%b exp=1", bus.load_ready);
    end
    if (bus.frame !== 1'b0) begin
      errors++; $display("FAIL mid_rst_frame got=%b exp=0", bus.frame);
    end
    tick();
    rst = 1'b0;
    wait_frame();
    push_frame('0, '0, 1'b0, 3, 0, 2 * FRAME_LEN - 1);
    drain();
  endtask

  task automatic test_scan();
    do_load(16'h1234, 4'h0);
    wait_ready();
    wait_frame();
    push_frame(16'h1234, 4'h0, 1'b0, 3, 0, FRAME_LEN - 1);
    drain();
  endtask

  task automatic test_tear_free();
    do_load(16'h0000, 4'h0);
    wait_ready();
    wait_frame();
    push_frame(16'h0000, 4'h0, 1'b0, 3, 0, FRAME_LEN - 1);
    repeat (10) tick();
    bus.digits_i   = 16'h5678;
    bus.dp_i       = 4'h0;
    bus.load_valid = 1'b1;
    tick();
    // Hold valid with other data while not ready: must be ignored.
    bus.digits_i = 16'h9999;
    bus.dp_i     = 4'hF;
    for (int j = 11; j < 14; j++) begin
      checks++;
      if (bus.load_ready !== 1'b0) begin
        errors++; $display("FAIL tear_ready pos=%0d got=%b exp=0", j, bus.load_ready);
      end
      tick();
    end
    bus.load_valid = 1'b0;
    for (int j = 14; j < 30; j++) tick();
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++; $display("FAIL tear_ready_pre got=%b exp=0", bus.load_ready);
    end
    tick();
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++; $display("FAIL tear_ready_rise got=%b exp=1", bus.load_ready);
    end
    push_frame(16'h5678, 4'h0, 1'b0, 3, FRAME_LEN, 2 * FRAME_LEN - 1);
    drain();
  endtask

  task automatic test_boundary_load();
    wait_frame();
    push_frame(16'h5678, 4'h0, 1'b0, 3, 0, FRAME_LEN - 1);
    repeat (FRAME_LEN - 2) tick();
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++; $display("FAIL bnd_ready got=%b exp=1", bus.load_ready);
    end
    bus.digits_i   = 16'h4321;
    bus.dp_i       = 4'h2;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++; $display("FAIL bnd_accept got=%b exp=0", bus.load_ready);
    end
    push_frame(16'h5678, 4'h0, 1'b0, 3, FRAME_LEN, 2 * FRAME_LEN - 1);
    push_frame(16'h4321, 4'h2, 1'b0, 3, 2 * FRAME_LEN, 3 * FRAME_LEN - 1);
    drain();
  endtask

  task automatic test_leading_zeros();
    bus.blank_lz = 1'b1;
    do_load(16'h0070, 4'b1000);
    wait_ready();
    wait_frame();
    push_frame(16'h0070, 4'b1000, 1'b1, 3, 0, FRAME_LEN - 1);
    drain();
    bus.blank_lz = 1'b0;
    wait_frame();
    push_frame(16'h0070, 4'b1000, 1'b0, 3, 0, FRAME_LEN - 1);
    drain();
  endtask

  task automatic test_brightness();
    for (int b = 0; b < 3; b++) begin
      bus.brightness = BRIGHT_BITS'(b);
      wait_frame();
      push_frame(16'h0070, 4'b1000, 1'b0, b, 0, FRAME_LEN - 1);
      drain();
    end
    bus.brightness = 2'd3;
  endtask

  task automatic test_hex();
    logic [15:0] vals [3];
    logic [3:0]  dps  [3];
    logic        blks [3];
    vals[0] = 16'h0A0A; dps[0] = 4'b0101; blks[0] = 1'b1;
    vals[1] = 16'hFEDC; dps[1] = 4'b0000; blks[1] = 1'b0;
    vals[2] = 16'hBA98; dps[2] = 4'b1001; blks[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.blank_lz = blks[i];
      do_load(vals[i], dps[i]);
      wait_ready();
      wait_frame();
      push_frame(vals[i], dps[i], blks[i], 3, 0, FRAME_LEN - 1);
      drain();
    end
    bus.blank_lz = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.digits_i   = '0;
    bus.dp_i       = '0;
    bus.load_valid = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.brightness = 2'd3;
    test_reset();
    test_scan();
    test_tear_free();
    test_boundary_load();
    test_leading_zeros();
    test_brightness();
    test_hex();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
